// File: rtl/rc4_search_pkg.sv
// Shared types and default key-space constants for the RC4 key search controller.
//   search_state_t : controller state encoding
//   DEF_KEY_*      : default key width and search bounds
package rc4_search_pkg;

  localparam int unsigned DEF_KEY_WIDTH = 24;
  localparam logic [23:0] DEF_KEY_START = 24'h000000;
  localparam logic [23:0] DEF_KEY_END   = 24'h3FFFFF;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START_CORE,
    WAIT_CORE,
    WAIT_CHECK,
    NEXT,
    FOUND,
    FAIL
  } search_state_t;

  // States in which the controller is parked and not driving a search.
  function automatic logic is_parked(search_state_t s);
    return (s == IDLE) || (s == FOUND) || (s == FAIL);
  endfunction

endpackage

// File: rtl/key_stepper.sv
// Candidate key register with overflow-safe increment and upper-bound check.
//   CLOCK_50, reset : clock, async active-high reset (key -> KEY_START)
//   load_start      : reload KEY_START (has priority over step)
//   step            : advance key by KEY_STEP
//   key             : current candidate (registered)
//   exhausted       : next candidate would exceed KEY_END (decoded from key only)
module key_stepper
  import rc4_search_pkg::*;
#(
  parameter int unsigned          KEY_WIDTH = DEF_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_START = KEY_WIDTH'(DEF_KEY_START),
  parameter logic [KEY_WIDTH-1:0] KEY_END   = KEY_WIDTH'(DEF_KEY_END),
  parameter int unsigned          KEY_STEP  = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic                 step,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 exhausted
);

  localparam int unsigned SUM_W = KEY_WIDTH + 1;

  logic [KEY_WIDTH-1:0] key_q;
  logic [SUM_W-1:0]     sum;

  // One extra bit so a step past the top of the key space is caught, not wrapped.
  assign sum       = {1'b0, key_q} + SUM_W'(KEY_STEP);
  assign exhausted = (sum > {1'b0, KEY_END});
  assign key       = key_q;

  // Key register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_q <= KEY_START;
    end else if (load_start) begin
      key_q <= KEY_START;
    end else if (step) begin
      key_q <= sum[KEY_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Exhaustive RC4 key search sequencer: per candidate it clears the checker,
// launches the RC4 core, waits for core and checker, then stops or advances.
//   CLOCK_50, reset  : clock, async active-high reset
//   start, abort     : begin search / return to IDLE (abort wins)
//   core_done        : RC4 core finished current key
//   chk_finish       : checker finished; chk_key_valid is its verdict
//   secret_key       : current candidate key
//   core_start       : one-cycle core launch pulse
//   chk_rst          : checker reset
//   busy             : search in progress
//   key_found        : parked with the valid key
//   search_fail      : parked after exhaustion or timeout; timeout flags the latter
module rc4_key_search_ctrl
  import rc4_search_pkg::*;
#(
  parameter int unsigned          KEY_WIDTH      = DEF_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_START      = KEY_WIDTH'(DEF_KEY_START),
  parameter logic [KEY_WIDTH-1:0] KEY_END        = KEY_WIDTH'(DEF_KEY_END),
  parameter int unsigned          KEY_STEP       = 1,
  parameter int unsigned          SETTLE_CYCLES  = 2,
  parameter int unsigned          TIMEOUT_CYCLES = 2**20
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 core_done,
  input  logic                 chk_finish,
  input  logic                 chk_key_valid,
  output logic [KEY_WIDTH-1:0] secret_key,
  output logic                 core_start,
  output logic                 chk_rst,
  output logic                 busy,
  output logic                 key_found,
  output logic                 search_fail,
  output logic                 timeout
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  search_state_t       state_q, state_d;
  logic [SETTLE_W-1:0] settle_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [TMO_W-1:0]    tmo_next;
  logic                load_start;
  logic                step;
  logic                exhausted;
  logic                tmo_fail;

  logic core_start_q, chk_rst_q, busy_q, key_found_q, search_fail_q, timeout_q;

  key_stepper #(
    .KEY_WIDTH (KEY_WIDTH),
    .KEY_START (KEY_START),
    .KEY_END   (KEY_END),
    .KEY_STEP  (KEY_STEP)
  ) u_key_stepper (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .load_start (load_start),
    .step       (step),
    .key        (secret_key),
    .exhausted  (exhausted)
  );

  assign tmo_next = tmo_q + TMO_W'(1);

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and key-stepper control.
  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    step       = 1'b0;
    tmo_fail   = 1'b0;

    if (abort) begin
      state_d    = IDLE;
      load_start = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          load_start = 1'b1;
          if (start) state_d = CLEAR;
        end
        CLEAR: begin
          state_d = START_CORE;
        end
        START_CORE: begin
          // core_done is deliberately not looked at in the launch cycle.
          state_d = WAIT_CORE;
        end
        WAIT_CORE: begin
          if (core_done) begin
            state_d = WAIT_CHECK;
          end else if (tmo_next == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d  = FAIL;
            tmo_fail = 1'b1;
          end
        end
        WAIT_CHECK: begin
          // Finish is only trusted once the checker has had time to settle.
          if ((settle_q == '0) && chk_finish) begin
            state_d = chk_key_valid ? FOUND : NEXT;
          end
        end
        NEXT: begin
          if (exhausted) begin
            state_d = FAIL;
          end else begin
            step    = 1'b1;
            state_d = CLEAR;
          end
        end
        FOUND, FAIL: begin
          if (start) begin
            state_d    = IDLE;
            load_start = 1'b1;
          end
        end
        default: begin
          state_d    = IDLE;
          load_start = 1'b1;
        end
      endcase
    end
  end

  // Settle and timeout counters, both armed in the launch cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      settle_q <= '0;
      tmo_q    <= '0;
    end else if (state_q == START_CORE) begin
      settle_q <= SETTLE_W'(SETTLE_CYCLES);
      tmo_q    <= '0;
    end else begin
      if (state_q == WAIT_CORE) tmo_q <= tmo_next;
      if ((state_q == WAIT_CHECK) && (settle_q != '0)) settle_q <= settle_q - SETTLE_W'(1);
    end
  end

  // Registered outputs decoded from the upcoming state.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      core_start_q  <= 1'b0;
      chk_rst_q     <= 1'b1;
      busy_q        <= 1'b0;
      key_found_q   <= 1'b0;
      search_fail_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      core_start_q  <= (state_d == START_CORE);
      chk_rst_q     <= (state_d == CLEAR);
      busy_q        <= !is_parked(state_d);
      key_found_q   <= (state_d == FOUND);
      search_fail_q <= (state_d == FAIL);
      // Timeout flag survives while parked in FAIL, cleared on leaving it.
      timeout_q     <= (state_d == FAIL) && (tmo_fail || ((state_q == FAIL) && timeout_q));
    end
  end

  assign core_start  = core_start_q;
  assign chk_rst     = chk_rst_q;
  assign busy        = busy_q;
  assign key_found   = key_found_q;
  assign search_fail = search_fail_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
module tb_rc4_key_search_ctrl;

  logic CLOCK_50;
  logic reset;
  logic start, abort, core_done, chk_finish, chk_key_valid;

  logic [23:0] key_a, key_b;
  logic cs_a, cr_a, busy_a, kf_a, sf_a, to_a;
  logic cs_b, cr_b, busy_b, kf_b, sf_b, to_b;

  logic        sel;
  logic [23:0] key_m;
  logic        cs_m, cr_m, busy_m, kf_m, sf_m, to_m;

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] tried[$];

  // Instance A: default key space, short timeout.
  rc4_key_search_ctrl #(
    .TIMEOUT_CYCLES (16)
  ) dut_a (
    .CLOCK_50 (CLOCK_50), .reset (reset), .start (start), .abort (abort),
    .core_done (core_done), .chk_finish (chk_finish), .chk_key_valid (chk_key_valid),
    .secret_key (key_a), .core_start (cs_a), .chk_rst (cr_a), .busy (busy_a),
    .key_found (kf_a), .search_fail (sf_a), .timeout (to_a)
  );

  // Instance B: tiny key space with stride 2.
  rc4_key_search_ctrl #(
    .KEY_START (24'h000000),
    .KEY_END   (24'h000005),
    .KEY_STEP  (2)
  ) dut_b (
    .CLOCK_50 (CLOCK_50), .reset (reset), .start (start), .abort (abort),
    .core_done (core_done), .chk_finish (chk_finish), .chk_key_valid (chk_key_valid),
    .secret_key (key_b), .core_start (cs_b), .chk_rst (cr_b), .busy (busy_b),
    .key_found (kf_b), .search_fail (sf_b), .timeout (to_b)
  );

  assign key_m  = sel ? key_b  : key_a;
  assign cs_m   = sel ? cs_b   : cs_a;
  assign cr_m   = sel ? cr_b   : cr_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign kf_m   = sel ? kf_b   : kf_a;
  assign sf_m   = sel ? sf_b   : sf_a;
  assign to_m   = sel ? to_b   : to_a;

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic st, ab, cd, cf, cv;
    logic e_cs, e_cr, e_busy, e_kf, e_sf;
    logic [23:0] e_key;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t v(input logic st, ab, cd, cf, cv,
                             input logic cs, cr, b, kf, sf, input logic [23:0] k);
    vec_t r;
    r.st = st; r.ab = ab; r.cd = cd; r.cf = cf; r.cv = cv;
    r.e_cs = cs; r.e_cr = cr; r.e_busy = b; r.e_kf = kf; r.e_sf = sf; r.e_key = k;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; core_done = 0; chk_finish = 0; chk_key_valid = 0;
  endtask

  task automatic do_abort();
    abort = 1; tick(); abort = 0; tick();
  endtask

  task automatic kick();
    start = 1; tick(); start = 0;
  endtask

  // Plays core and checker for each launched key until the search parks,
  // or returns at the START_CORE cycle of hang_key when use_hang is set.
  task automatic run_search(input logic [23:0] target, input logic [23:0] hang_key,
                            input bit use_hang, output int n_starts);
    int  w;
    bit  done;
    n_starts = 0;
    done = 0;
    tried.delete();
    while (!done) begin
      w = 0;
      while (!cs_m && !kf_m && !sf_m && w < 40) begin
        tick();
        w++;
      end
      if (w >= 40) begin
        check("wait_core_start_bound", 32'(w), 32'(0));
        done = 1;
      end else if (kf_m || sf_m) begin
        done = 1;
      end else begin
        n_starts++;
        tried.push_back(key_m);
        if ((use_hang && key_m == hang_key) || n_starts > 64) begin
          done = 1;
        end else begin
          tick(); core_done = 1;
          tick(); core_done = 0; chk_finish = 1; chk_key_valid = (key_m == target);
          tick();
          tick();
          tick(); chk_finish = 0; chk_key_valid = 0;
        end
      end
    end
  endtask

  initial begin
    int ns;
    CLOCK_50 = 0;
    sel = 0;
    idle_inputs();
    reset = 1;

    vecs[0]  = v(1,0,0,0,0, 0,0,0,0,0, 24'd0);
    vecs[1]  = v(0,0,0,0,0, 0,1,1,0,0, 24'd0);
    vecs[2]  = v(0,0,1,0,0, 1,0,1,0,0, 24'd0);
    vecs[3]  = v(0,0,0,0,0, 0,0,1,0,0, 24'd0);
    vecs[4]  = v(0,0,1,0,0, 0,0,1,0,0, 24'd0);
    vecs[5]  = v(0,0,0,1,1, 0,0,1,0,0, 24'd0);
    vecs[6]  = v(0,0,0,0,0, 0,0,1,0,0, 24'd0);
    vecs[7]  = v(0,0,0,1,0, 0,0,1,0,0, 24'd0);
    vecs[8]  = v(0,0,0,0,0, 0,0,1,0,0, 24'd0);
    vecs[9]  = v(0,0,0,0,0, 0,1,1,0,0, 24'd1);
    vecs[10] = v(0,0,0,0,0, 1,0,1,0,0, 24'd1);
    vecs[11] = v(0,0,1,0,0, 0,0,1,0,0, 24'd1);
    vecs[12] = v(0,0,0,1,1, 0,0,1,0,0, 24'd1);
    vecs[13] = v(0,0,0,1,1, 0,0,1,0,0, 24'd1);
    vecs[14] = v(0,0,0,1,1, 0,0,1,0,0, 24'd1);
    vecs[15] = v(0,0,0,0,0, 0,0,0,1,0, 24'd1);
    vecs[16] = v(1,0,0,0,0, 0,0,0,1,0, 24'd1);
    vecs[17] = v(1,1,0,0,0, 0,0,0,0,0, 24'd0);
    vecs[18] = v(0,0,0,0,0, 0,0,0,0,0, 24'd0);

    // Reset values while reset is held.
    repeat (2) tick();
    check("rst_key",         32'(key_a),  32'(0));
    check("rst_chk_rst",     32'(cr_a),   32'(1));
    check("rst_core_start",  32'(cs_a),   32'(0));
    check("rst_busy",        32'(busy_a), 32'(0));
    check("rst_found_fail",  32'({kf_a, sf_a, to_a}), 32'(0));
    reset = 0;
    tick();
    check("post_rst_chk_rst", 32'(cr_a), 32'(0));
    tick();

    // Cycle-by-cycle trace: ignored core_done at launch, early finish discard,
    // level finish honoured, FOUND restart, abort beating start.
    for (int i = 0; i < 19; i++) begin
      check($sformatf("vec%0d_core_start", i), 32'(cs_a),   32'(vecs[i].e_cs));
      check($sformatf("vec%0d_chk_rst", i),    32'(cr_a),   32'(vecs[i].e_cr));
      check($sformatf("vec%0d_busy", i),       32'(busy_a), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_key_found", i),  32'(kf_a),   32'(vecs[i].e_kf));
      check($sformatf("vec%0d_search_fail", i),32'(sf_a),   32'(vecs[i].e_sf));
      check($sformatf("vec%0d_key", i),        32'(key_a),  32'(vecs[i].e_key));
      start = vecs[i].st; abort = vecs[i].ab; core_done = vecs[i].cd;
      chk_finish = vecs[i].cf; chk_key_valid = vecs[i].cv;
      tick();
    end
    idle_inputs();
    do_abort();

    // Valid at key 3.
    kick();
    run_search(24'd3, 24'd0, 0, ns);
    check("k3_starts",      32'(ns),    32'(4));
    check("k3_key_found",   32'(kf_a),  32'(1));
    check("k3_key",         32'(key_a), 32'(3));
    check("k3_search_fail", 32'(sf_a),  32'(0));
    check("k3_busy",        32'(busy_a),32'(0));
    do_abort();

    // Exhaustion on instance B: keys 0, 2, 4.
    sel = 1;
    kick();
    run_search(24'hFFFFFF, 24'd0, 0, ns);
    check("exh_starts", 32'(ns), 32'(3));
    for (int i = 0; i < 3 && i < tried.size(); i++)
      check($sformatf("exh_key%0d", i), 32'(tried[i]), 32'(2 * i));
    check("exh_search_fail", 32'(sf_b),  32'(1));
    check("exh_key",         32'(key_b), 32'(4));
    check("exh_timeout",     32'(to_b),  32'(0));
    check("exh_key_found",   32'(kf_b),  32'(0));
    sel = 0;
    do_abort();

    // Restart from FOUND at key 9.
    kick();
    run_search(24'd9, 24'd0, 0, ns);
    check("r9_found", 32'(kf_a),  32'(1));
    check("r9_key",   32'(key_a), 32'(9));
    start = 1; tick();
    check("r9_idle_key",  32'(key_a),  32'(0));
    check("r9_idle_busy", 32'(busy_a), 32'(0));
    check("r9_idle_kf",   32'(kf_a),   32'(0));
    tick(); start = 0;
    check("r9_chk_rst",   32'(cr_a),  32'(1));
    check("r9_clear_key", 32'(key_a), 32'(0));
    tick();
    check("r9_core_start", 32'(cs_a),  32'(1));
    check("r9_launch_key", 32'(key_a), 32'(0));
    do_abort();

    // Abort in WAIT_CORE at key 7.
    kick();
    run_search(24'hFFFFFF, 24'd7, 1, ns);
    check("ab7_starts", 32'(ns),    32'(8));
    check("ab7_key",    32'(key_a), 32'(7));
    tick();
    abort = 1; tick(); abort = 0;
    check("ab7_busy",       32'(busy_a), 32'(0));
    check("ab7_key_after",  32'(key_a),  32'(0));
    check("ab7_core_start", 32'(cs_a),   32'(0));
    tick();

    // Timeout: core never finishes.
    kick();
    run_search(24'hFFFFFF, 24'd0, 1, ns);
    check("to_launch", 32'(cs_a), 32'(1));
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        check("to_pre_fail", 32'(sf_a),   32'(0));
        check("to_pre_busy", 32'(busy_a), 32'(1));
      end
    end
    check("to_search_fail", 32'(sf_a),   32'(1));
    check("to_timeout",     32'(to_a),   32'(1));
    check("to_busy",        32'(busy_a), 32'(0));
    check("to_key",         32'(key_a),  32'(0));
    do_abort();
    check("to_cleared", 32'({sf_a, to_a}), 32'(0));

    // Async reset in WAIT_CHECK at key 2.
    kick();
    run_search(24'hFFFFFF, 24'd2, 1, ns);
    check("rs_key_before", 32'(key_a), 32'(2));
    tick(); core_done = 1;
    tick(); core_done = 0;
    @(posedge CLOCK_50);
    #2 reset = 1;
    #1;
    check("rs_key",        32'(key_a),  32'(0));
    check("rs_busy",       32'(busy_a), 32'(0));
    check("rs_chk_rst",    32'(cr_a),   32'(1));
    check("rs_core_start", 32'(cs_a),   32'(0));
    check("rs_flags",      32'({kf_a, sf_a, to_a}), 32'(0));
    tick();
    reset = 0;
    tick();
    check("rs_post_chk_rst", 32'(cr_a),   32'(0));
    check("rs_post_busy",    32'(busy_a), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
